result_checker: RTL and testbench
=================================

Name: result_checker

Overview:
- Reads back the captured DUT results from the output BRAM after the capture controller has filled it.
- Compares each word against a golden-result BRAM that shares the same address space.
- Reports mismatch count, first failing address and an accumulated bit-error mask to ChipScope/LEDs, so one overclocking run gives pass/fail without a manual ILA dump.
- Runs entirely in the 200 MHz system clock domain and sits beside the control block on the BRAM read port.

Parameters:
AddrWL, 9, BRAM address width; depth = 2^AddrWL words
DataWL, 40, result word width (matches DUT output width)

Ports:
clk  input  1  system clock (200 MHz)
nrst  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begin a check pass
word_count  input  AddrWL+1  number of words to check, 0..2^AddrWL, sampled on start
ram_en  output  1  read enable to result BRAM and golden BRAM
ram_addr  output  AddrWL  shared read address for both BRAMs
ram_dout  input  DataWL  result BRAM data, valid 1 cycle after ram_en
gold_dout  input  DataWL  golden BRAM data, valid 1 cycle after ram_en
busy  output  1  high while a pass is in progress
done  output  1  high from end of pass until next start or reset
pass  output  1  valid when done: 1 iff err_count==0
err_count  output  AddrWL+1  number of mismatching words
first_err_addr  output  AddrWL  address of the first mismatch
first_err_valid  output  1  at least one mismatch recorded
err_mask  output  DataWL  OR over all mismatching words of (ram_dout XOR gold_dout)

Behaviour:
- Reset (async, nrst=0): state IDLE.
- Reset values: ram_en=0, ram_addr=0, busy=0, done=0, pass=0, err_count=0, first_err_addr=0, first_err_valid=0, err_mask=0.
- States:
  - IDLE -> on start: latch word_count to remaining, clear all result registers, done=0.
    - If word_count==0: go to DONE next cycle, with pass=1.
    - Otherwise go to READ.
  - READ: ram_en=1 and ram_addr increments by 1 each cycle from 0. After issuing address word_count-1, go to DRAIN.
  - DRAIN: ram_en=0; one cycle to compare the last returned word; then go to DONE.
  - DONE: done=1, busy=0, pass=(err_count==0). On start, behave as IDLE on start.
- busy=1 in READ and DRAIN.
- Compare pipeline: a 1-cycle delayed copy of ram_en/ram_addr qualifies comparison of ram_dout vs gold_dout. Address issued at cycle t is compared at t+1.
- Total latency for N>0 words: start at cycle 0, done rises at cycle N+2.
- On mismatch:
  - err_count += 1; it cannot overflow because width is AddrWL+1 and N ≤ 2^AddrWL.
  - If first_err_valid==0: load first_err_addr with the delayed address and set first_err_valid=1.
  - err_mask |= ram_dout ^ gold_dout.
- Full depth: word_count=2^AddrWL. ram_addr goes 0..2^AddrWL-1 with no wrap issued; the internal remaining counter is AddrWL+1 bits wide.
- word_count > 2^AddrWL is impossible by width (max value 2^AddrWL).
- start while busy: ignored; the pass continues unchanged.
- start in the same cycle as the final DRAIN compare: ignored, because that cycle is still busy.
- Reset mid-pass: immediate return to reset values; a later start runs a clean pass.

Test Plan:
- Golden and result BRAMs identical (word i = i), start with word_count=16 -> ram_addr 0..15 on consecutive cycles; done at cycle 18; pass=1, err_count=0, err_mask=0, first_err_valid=0.
- Result word 5 has bit 3 flipped, word_count=16 -> err_count=1, first_err_addr=5, first_err_valid=1, err_mask=0x0000000008, pass=0.
- Words 2 and 9 differ by 0x01 and 0x8000000000 -> err_count=2, first_err_addr=2, err_mask=0x8000000001.
- word_count=0 -> ram_en never asserts; done=1 one cycle after start; pass=1; err_count=0.
- word_count=512 with every word mismatching -> err_count=512 with no overflow; last ram_addr=511; first_err_addr=0.
- Apply a second start at cycle 4 of a 16-word pass -> it is ignored and results equal a single pass. Drop nrst at cycle 8 -> all outputs return to 0 immediately. Start again after release -> a clean, correct pass.

Source files
------------

// File: rtl/result_checker.sv
// result_checker: reads the result and golden BRAMs over a shared address
// sweep, compares them word by word and reports the mismatch count, the
// first failing address and an OR-accumulated bit-error mask.
//
// Ports:
//   clk_i             system clock
//   nrst_i            asynchronous active-low reset
//   start_i           single-cycle pulse, begins a check pass (ignored while busy)
//   word_count_i      number of words to check, 0..2^AddrWL, sampled on start
//   ram_en_o          read enable to both BRAMs
//   ram_addr_o        shared read address for both BRAMs
//   ram_dout_i        result BRAM data, valid one cycle after ram_en_o
//   gold_dout_i       golden BRAM data, valid one cycle after ram_en_o
//   busy_o            pass in progress
//   done_o            pass finished, held until next start or reset
//   pass_o            valid when done: no mismatches seen
//   err_count_o       number of mismatching words
//   first_err_addr_o  address of the first mismatch
//   first_err_valid_o at least one mismatch recorded
//   err_mask_o        OR of (result ^ golden) over all mismatching words
module result_checker #(
    parameter int unsigned AddrWL = 9,
    parameter int unsigned DataWL = 40
) (
    input  logic              clk_i,
    input  logic              nrst_i,
    input  logic              start_i,
    input  logic [AddrWL:0]   word_count_i,
    output logic              ram_en_o,
    output logic [AddrWL-1:0] ram_addr_o,
    input  logic [DataWL-1:0] ram_dout_i,
    input  logic [DataWL-1:0] gold_dout_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [AddrWL:0]   err_count_o,
    output logic [AddrWL-1:0] first_err_addr_o,
    output logic              first_err_valid_o,
    output logic [DataWL-1:0] err_mask_o
);

    localparam logic [AddrWL:0]   CntOne  = 1;
    localparam logic [AddrWL-1:0] AddrOne = 1;

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

    state_e              state_q, state_d;
    logic [AddrWL:0]     remaining_q, remaining_d;
    logic [AddrWL-1:0]   addr_q, addr_d;
    // One-cycle delayed enable/address line up with the BRAM read data.
    logic                cmp_en_q, cmp_en_d;
    logic [AddrWL-1:0]   cmp_addr_q, cmp_addr_d;
    logic [AddrWL:0]     err_count_q, err_count_d;
    logic [AddrWL-1:0]   first_err_addr_q, first_err_addr_d;
    logic                first_err_valid_q, first_err_valid_d;
    logic [DataWL-1:0]   err_mask_q, err_mask_d;
    logic [DataWL-1:0]   diff;
    logic                mismatch;

    always_comb begin
        state_d           = state_q;
        remaining_d       = remaining_q;
        addr_d            = addr_q;
        err_count_d       = err_count_q;
        first_err_addr_d  = first_err_addr_q;
        first_err_valid_d = first_err_valid_q;
        err_mask_d        = err_mask_q;

        diff     = ram_dout_i ^ gold_dout_i;
        mismatch = cmp_en_q && (diff != '0);

        cmp_en_d   = (state_q == StRead);
        cmp_addr_d = addr_q;

        if (mismatch) begin
            err_count_d = err_count_q + CntOne;
            err_mask_d  = err_mask_q | diff;
            if (!first_err_valid_q) begin
                first_err_addr_d  = cmp_addr_q;
                first_err_valid_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle, StDone: begin
                // cmp_en_q is low here, so clearing cannot collide with an update.
                if (start_i) begin
                    remaining_d       = word_count_i;
                    addr_d            = '0;
                    err_count_d       = '0;
                    first_err_addr_d  = '0;
                    first_err_valid_d = 1'b0;
                    err_mask_d        = '0;
                    state_d           = (word_count_i == '0) ? StDone : StRead;
                end
            end
            StRead: begin
                remaining_d = remaining_q - CntOne;
                // Hold the last address rather than wrap on a full-depth pass.
                if (remaining_q == CntOne) begin
                    state_d = StDrain;
                end else begin
                    addr_d = addr_q + AddrOne;
                end
            end
            StDrain: begin
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q           <= StIdle;
            remaining_q       <= '0;
            addr_q            <= '0;
            cmp_en_q          <= 1'b0;
            cmp_addr_q        <= '0;
            err_count_q       <= '0;
            first_err_addr_q  <= '0;
            first_err_valid_q <= 1'b0;
            err_mask_q        <= '0;
        end else begin
            state_q           <= state_d;
            remaining_q       <= remaining_d;
            addr_q            <= addr_d;
            cmp_en_q          <= cmp_en_d;
            cmp_addr_q        <= cmp_addr_d;
            err_count_q       <= err_count_d;
            first_err_addr_q  <= first_err_addr_d;
            first_err_valid_q <= first_err_valid_d;
            err_mask_q        <= err_mask_d;
        end
    end

    assign ram_en_o          = (state_q == StRead);
    assign ram_addr_o        = addr_q;
    assign busy_o            = (state_q == StRead) || (state_q == StDrain);
    assign done_o            = (state_q == StDone);
    assign pass_o            = done_o && (err_count_q == '0);
    assign err_count_o       = err_count_q;
    assign first_err_addr_o  = first_err_addr_q;
    assign first_err_valid_o = first_err_valid_q;
    assign err_mask_o        = err_mask_q;

endmodule

// File: tb/tb_result_checker.sv
// Directed bench for result_checker with behavioural result/golden BRAMs.
module tb_result_checker;

    localparam int AW = 9;
    localparam int DW = 40;
    localparam int Depth = 1 << AW;

    logic          clk = 1'b0;
    logic          nrst;
    logic          start;
    logic [AW:0]   word_count;
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout;
    logic [DW-1:0] gold_dout;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW:0]   err_count;
    logic [AW-1:0] first_err_addr;
    logic          first_err_valid;
    logic [DW-1:0] err_mask;

    logic [DW-1:0] res_mem  [Depth];
    logic [DW-1:0] gold_mem [Depth];

    int checks = 0;
    int fails  = 0;

    // Read-port monitor: enable count, address continuity and last address.
    int            en_total = 0;
    int            addr_bad = 0;
    logic          prev_en = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [AW-1:0] last_addr = '0;

    always #2.5 clk = ~clk;

    result_checker #(.AddrWL(AW), .DataWL(DW)) dut (
        .clk_i             (clk),
        .nrst_i            (nrst),
        .start_i           (start),
        .word_count_i      (word_count),
        .ram_en_o          (ram_en),
        .ram_addr_o        (ram_addr),
        .ram_dout_i        (ram_dout),
        .gold_dout_i       (gold_dout),
        .busy_o            (busy),
        .done_o            (done),
        .pass_o            (pass),
        .err_count_o       (err_count),
        .first_err_addr_o  (first_err_addr),
        .first_err_valid_o (first_err_valid),
        .err_mask_o        (err_mask)
    );

    // Synchronous-read BRAM models: data valid one cycle after enable.
    always @(posedge clk) begin
        if (ram_en) begin
            ram_dout  <= res_mem[ram_addr];
            gold_dout <= gold_mem[ram_addr];
        end
    end

    always @(posedge clk) begin
        if (ram_en) begin
            en_total  <= en_total + 1;
            last_addr <= ram_addr;
            if (prev_en && ram_addr !== prev_addr + 9'd1) addr_bad <= addr_bad + 1;
            if (!prev_en && ram_addr !== 9'd0) addr_bad <= addr_bad + 1;
        end
        prev_en   <= ram_en;
        prev_addr <= ram_addr;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string pre);
        check({pre, "/ram_en"}, 64'(ram_en), 64'd0);
        check({pre, "/ram_addr"}, 64'(ram_addr), 64'd0);
        check({pre, "/busy"}, 64'(busy), 64'd0);
        check({pre, "/done"}, 64'(done), 64'd0);
        check({pre, "/pass"}, 64'(pass), 64'd0);
        check({pre, "/err_count"}, 64'(err_count), 64'd0);
        check({pre, "/first_err_addr"}, 64'(first_err_addr), 64'd0);
        check({pre, "/first_err_valid"}, 64'(first_err_valid), 64'd0);
        check({pre, "/err_mask"}, 64'(err_mask), 64'd0);
    endtask

    task automatic init_mems();
        for (int i = 0; i < Depth; i++) begin
            gold_mem[i] = DW'(i);
            res_mem[i]  = DW'(i);
        end
    endtask

    // Start pulse in cycle 0; returns the first cycle with done high.
    // ss: cycle of an extra start pulse (0 = none); rc: stop at this cycle (0 = none).
    task automatic run_pass(input int n, input int ss, input int rc,
                            output int cyc, output int en_cnt, output int bad);
        int en0, bad0;
        en0  = en_total;
        bad0 = addr_bad;
        @(posedge clk); #1;
        start      = 1'b1;
        word_count = (AW+1)'(n);
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 2000 && !(rc != 0 && cyc == rc)) begin
            if (cyc == ss) begin
                start      = 1'b1;
                word_count = 10'd5;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start  = 1'b0;
        en_cnt = en_total - en0;
        bad    = addr_bad - bad0;
    endtask

    int cyc, en_cnt, bad;

    initial begin
        nrst       = 1'b0;
        start      = 1'b0;
        word_count = '0;
        init_mems();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        nrst = 1'b1;

        // Identical memories, 16 words.
        run_pass(16, 0, 0, cyc, en_cnt, bad);
        check("id16/latency", 64'(cyc), 64'd18);
        check("id16/en_cycles", 64'(en_cnt), 64'd16);
        check("id16/addr_seq", 64'(bad), 64'd0);
        check("id16/last_addr", 64'(last_addr), 64'd15);
        check("id16/pass", 64'(pass), 64'd1);
        check("id16/busy", 64'(busy), 64'd0);
        check("id16/err_count", 64'(err_count), 64'd0);
        check("id16/err_mask", 64'(err_mask), 64'd0);
        check("id16/first_valid", 64'(first_err_valid), 64'd0);

        // Word 5 bit 3 flipped.
        res_mem[5] = res_mem[5] ^ 40'h8;
        run_pass(16, 0, 0, cyc, en_cnt, bad);
        check("w5/latency", 64'(cyc), 64'd18);
        check("w5/err_count", 64'(err_count), 64'd1);
        check("w5/first_addr", 64'(first_err_addr), 64'd5);
        check("w5/first_valid", 64'(first_err_valid), 64'd1);
        check("w5/err_mask", 64'(err_mask), 64'h8);
        check("w5/pass", 64'(pass), 64'd0);

        // Words 2 and 9 differ.
        init_mems();
        res_mem[2] = res_mem[2] ^ 40'h01;
        res_mem[9] = res_mem[9] ^ 40'h80_0000_0000;
        run_pass(16, 0, 0, cyc, en_cnt, bad);
        check("w2w9/err_count", 64'(err_count), 64'd2);
        check("w2w9/first_addr", 64'(first_err_addr), 64'd2);
        check("w2w9/err_mask", 64'(err_mask), 64'h80_0000_0001);
        check("w2w9/pass", 64'(pass), 64'd0);

        // Zero-length pass.
        run_pass(0, 0, 0, cyc, en_cnt, bad);
        check("zero/latency", 64'(cyc), 64'd1);
        check("zero/en_cycles", 64'(en_cnt), 64'd0);
        check("zero/pass", 64'(pass), 64'd1);
        check("zero/err_count", 64'(err_count), 64'd0);
        check("zero/first_valid", 64'(first_err_valid), 64'd0);

        // Full depth, every word mismatching in every bit.
        init_mems();
        for (int i = 0; i < Depth; i++) res_mem[i] = ~gold_mem[i];
        run_pass(512, 0, 0, cyc, en_cnt, bad);
        check("full/latency", 64'(cyc), 64'd514);
        check("full/en_cycles", 64'(en_cnt), 64'd512);
        check("full/addr_seq", 64'(bad), 64'd0);
        check("full/last_addr", 64'(last_addr), 64'd511);
        check("full/err_count", 64'(err_count), 64'd512);
        check("full/first_addr", 64'(first_err_addr), 64'd0);
        check("full/err_mask", 64'(err_mask), 64'hFF_FFFF_FFFF);
        check("full/pass", 64'(pass), 64'd0);

        // Extra start at cycle 4 is ignored.
        init_mems();
        res_mem[5] = res_mem[5] ^ 40'h8;
        run_pass(16, 4, 0, cyc, en_cnt, bad);
        check("restart/latency", 64'(cyc), 64'd18);
        check("restart/en_cycles", 64'(en_cnt), 64'd16);
        check("restart/err_count", 64'(err_count), 64'd1);
        check("restart/first_addr", 64'(first_err_addr), 64'd5);
        check("restart/err_mask", 64'(err_mask), 64'h8);

        // Reset at cycle 8 after the word-5 mismatch has been counted.
        run_pass(16, 0, 8, cyc, en_cnt, bad);
        check("midrst/busy_before", 64'(busy), 64'd1);
        check("midrst/err_before", 64'(err_count), 64'd1);
        nrst = 1'b0;
        #1;
        check_zero("midrst");
        @(negedge clk);
        nrst = 1'b1;
        run_pass(16, 0, 0, cyc, en_cnt, bad);
        check("postrst/latency", 64'(cyc), 64'd18);
        check("postrst/en_cycles", 64'(en_cnt), 64'd16);
        check("postrst/err_count", 64'(err_count), 64'd1);
        check("postrst/first_addr", 64'(first_err_addr), 64'd5);
        check("postrst/err_mask", 64'(err_mask), 64'h8);
        check("postrst/pass", 64'(pass), 64'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
